qam_src_arbiter: RTL
====================

# qam_src_arbiter

Round-robin frame scheduler that shares the single `qam_top` modulator among `NUM_SRC` word sources. It grants one source at a time for a fixed frame of `FRAME_LEN` accepted words, programs the modulator's `qam` order for that source, and inserts a settle gap when the order changes. It also quarantines the datapath when the modulator raises `error`. It sits directly upstream of `qam_top`, between the source FIFOs and the modulator's input handshake.

## Interface
- `NUM_SRC`, 4: number of requesters, 2..8
- `DATA_W`, 32: word width, matches modulator `signal_in`
- `FRAME_LEN`, 16: accepted words per grant, ≥1
- `SETTLE_CYC`, 4: idle cycles after a `qam` change before the first word, ≥1
- `MAX_QAM`, 4: highest legal `qam` code
- `clk` in 1: sole clock, rising edge
- `rst` in 1: asynchronous, active-low reset
- `src_data` in NUM_SRC*DATA_W: packed source words; source i occupies bits [i*DATA_W +: DATA_W]
- `src_qam` in NUM_SRC*3: packed per-source `qam` code
- `src_valid` in NUM_SRC: source has a word
- `src_ready` out NUM_SRC: word accepted when `src_valid[i]` and `src_ready[i]` are both high
- `mod_signal_in` out DATA_W: to modulator `signal_in`
- `mod_valid_in` out 1: to modulator `valid_in`
- `mod_ready_out` in 1: from modulator `ready_out`
- `mod_qam` out 3: to modulator `qam`, registered
- `mod_error` in 1: from modulator `error`
- `err_clr` in 1: single-cycle pulse; releases the ERR state
- `grant` out NUM_SRC: one-hot current owner, registered
- `busy` out 1: high in any state except IDLE
- `frame_done` out 1: one-cycle pulse after a full frame
- `err` out 1: high while in ERR
- `err_src` out 3: index of the source granted when the error occurred
- `cfg_err` out NUM_SRC: sticky per-source flag, set on an illegal `qam` code; cleared only by reset

## Operation
- States: IDLE, SETTLE, XFER, ERR.
- Reset values: state IDLE; all outputs 0 (`grant`, `mod_qam`, `mod_valid_in`, `src_ready`, `busy`, `frame_done`, `err`, `err_src`, `cfg_err`); round-robin pointer 0; `last_qam_valid` 0.
- **Eligibility.** Source i is eligible when `src_valid[i]=1` and `src_qam[i] ≤ MAX_QAM`.
- **Illegal codes.** A source with `src_valid[i]=1` and `src_qam[i] > MAX_QAM` is never granted. It sets `cfg_err[i]` on the same edge.
- **IDLE.** Search for the first eligible source, starting at the pointer and wrapping. On a hit, register `grant`, `mod_qam` and the granted index, then clear the word counter.
  - If `last_qam_valid=1` and the new code equals the previous `mod_qam`, go to XFER.
  - Otherwise load the settle counter with `SETTLE_CYC` and go to SETTLE.
- **SETTLE.** `mod_valid_in=0` and all `src_ready=0`. Decrement the counter each cycle; leave for XFER on the edge where it reaches 0. Set `last_qam_valid` on entry to XFER.
- **XFER.** The datapath is a combinational mux on the granted index:
  - `mod_signal_in = src_data[g]`
  - `mod_valid_in = src_valid[g]`
  - `src_ready[g] = mod_ready_out`; all other `src_ready` are 0.
  - A word transfers when `src_valid[g]` and `mod_ready_out` are both high; the counter increments.
  - If the source deasserts valid, XFER holds with no timeout.
  - On the transfer that reaches `FRAME_LEN`: pointer ← (g+1) mod `NUM_SRC`, `grant` ← 0, pulse `frame_done` on the next cycle, go to IDLE.
- **Error entry.** `mod_error=1` in SETTLE or XFER goes to ERR. On that edge: `err_src` ← g, pointer ← (g+1) mod `NUM_SRC`, `grant` ← 0, `last_qam_valid` ← 0. The partial frame is abandoned and no `frame_done` is issued.
- **ERR.** `mod_valid_in=0`, all `src_ready=0`, `err=1`. Leave for IDLE on `err_clr=1` while `mod_error=0`.
- `mod_error` is ignored in IDLE.
- **Mid-operation reset.** Asynchronous return to reset values. No partial frame resumes.

## Timing
- Grant latency: first eligible `src_valid` at edge N → `grant` valid after edge N+1.
  - First word can transfer in cycle N+1 when `qam` is unchanged.
  - First word can transfer in cycle N+1+`SETTLE_CYC` when `qam` changed.
- `mod_qam` changes only on the IDLE→SETTLE/XFER edge. It is stable throughout SETTLE and XFER.
- Full throughput in XFER: one word per cycle while the source is valid and the modulator is ready.
- Back-to-back frames: one IDLE cycle between the last word of frame k and the earliest word of frame k+1.
- Final transfer and `mod_error` in the same cycle: the error wins. Go to ERR, no `frame_done`, but the word counts as accepted by the source.
- `err_clr` together with `mod_error=1`: remain in ERR.
- Only one source is granted at a time. `src_ready` is never high for a non-granted source.

## Test plan
- **Single source.** Reset, then source 0 valid with `qam=3`, modulator ready, `FRAME_LEN=16`, `SETTLE_CYC=4` → 4 SETTLE cycles, then exactly 16 transfers on consecutive cycles, then `frame_done` pulses once and `grant` returns to 0.
- **Round-robin.** All 4 sources valid with equal `qam` → grant order 0,1,2,3,0. Each frame is 16 words. No SETTLE after the first frame and one gap cycle between frames.
- **`qam` change.** Source 0 `qam=1`, source 1 `qam=2` → SETTLE of 4 cycles precedes source 1's first word, and `mod_qam` never changes inside a frame.
- **Backpressure.** `mod_ready_out` toggles every cycle and source 2 drops valid for 5 cycles mid-frame → exactly 16 words accepted with no duplicates or loss; data sequence equals the source's incrementing pattern.
- **Error.** `mod_error` rises on the 7th word of source 1 → ERR, `err=1`, `err_src=1`, all readies 0. After `err_clr`, the next grant goes to source 2 with a fresh SETTLE.
- **Illegal code and reset.** Source 3 `qam=6` → `cfg_err[3]=1` and it is never granted. Assert `rst` low mid-XFER → all outputs 0 immediately.

Source files
------------

// File: rtl/qam_src_arbiter.sv
// qam_src_arbiter
// Round-robin frame scheduler in front of the shared qam_top modulator.
// One source owns the modulator for FRAME_LEN accepted words. The modulator
// qam order is programmed from the owner's code. A settle gap is inserted
// whenever the order may have changed. A modulator error quarantines the
// datapath until software clears it.
//
// Ports
//   clk, rst           : clock (rising edge), asynchronous active-low reset
//   src_data/src_qam   : packed per-source word and qam code (source i at slot i)
//   src_valid/src_ready: per-source handshake
//   mod_signal_in/mod_valid_in/mod_ready_out : modulator input handshake
//   mod_qam            : registered qam order for the modulator
//   mod_error, err_clr : modulator fault input, single-cycle release pulse
//   grant              : one-hot current owner
//   busy, frame_done, err, err_src : status
//   cfg_err            : sticky per-source illegal-qam flag
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | no owner, searching for the next eligible source
// S_SETTLE | owner granted, modulator settling after a qam change
// S_XFER   | owner's words are muxed straight through to the modulator
// S_ERR    | modulator faulted, datapath quarantined until err_clr
module qam_src_arbiter #(
   parameter int NUM_SRC    = 4,
   parameter int DATA_W     = 32,
   parameter int FRAME_LEN  = 16,
   parameter int SETTLE_CYC = 4,
   parameter int MAX_QAM    = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_SRC*DATA_W-1:0] src_data,
   input  logic [NUM_SRC*3-1:0]      src_qam,
   input  logic [NUM_SRC-1:0]        src_valid,
   output logic [NUM_SRC-1:0]        src_ready,
   output logic [DATA_W-1:0]         mod_signal_in,
   output logic                      mod_valid_in,
   input  logic                      mod_ready_out,
   output logic [2:0]                mod_qam,
   input  logic                      mod_error,
   input  logic                      err_clr,
   output logic [NUM_SRC-1:0]        grant,
   output logic                      busy,
   output logic                      frame_done,
   output logic                      err,
   output logic [2:0]                err_src,
   output logic [NUM_SRC-1:0]        cfg_err
);

   localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
   localparam int CNT_W = $clog2(FRAME_LEN + 1);
   localparam int SET_W = $clog2(SETTLE_CYC + 1);

   localparam logic [CNT_W-1:0]   LAST_WORD = CNT_W'(FRAME_LEN - 1);
   localparam logic [SET_W-1:0]   SETTLE_LD = SET_W'(SETTLE_CYC);
   localparam logic [SET_W-1:0]   SETTLE_TC = SET_W'(1);
   localparam logic [2:0]         QAM_MAX   = 3'(MAX_QAM);
   localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(NUM_SRC - 1);
   localparam logic [NUM_SRC-1:0] GRANT_ONE = NUM_SRC'(1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SETTLE,
      S_XFER,
      S_ERR
   } state_t;

   state_t r_state;
   state_t w_state_nxt;

   logic [NUM_SRC-1:0] r_grant;
   logic [IDX_W-1:0]   r_gidx;
   logic [IDX_W-1:0]   r_ptr;
   logic [2:0]         r_qam;
   logic               r_last_qam_valid;
   logic [CNT_W-1:0]   r_cnt;
   logic [SET_W-1:0]   r_settle;
   logic               r_frame_done;
   logic [IDX_W-1:0]   r_err_src;
   logic [NUM_SRC-1:0] r_cfg_err;

   logic [DATA_W-1:0]  w_data [NUM_SRC];
   logic [2:0]         w_qam  [NUM_SRC];
   logic [NUM_SRC-1:0] w_elig;
   logic [NUM_SRC-1:0] w_illegal;

   logic               w_hit;
   logic [IDX_W-1:0]   w_sel;
   logic [IDX_W-1:0]   w_idx;
   logic               w_take;
   logic               w_fire;
   logic               w_last;
   logic               w_err_entry;
   logic [IDX_W-1:0]   w_ptr_nxt;

   genvar gi;
   for (gi = 0; gi < NUM_SRC; gi++) begin : g_unpack
      assign w_data[gi]    = src_data[gi*DATA_W +: DATA_W];
      assign w_qam[gi]     = src_qam[gi*3 +: 3];
      assign w_illegal[gi] = src_valid[gi] && (w_qam[gi] > QAM_MAX);
      assign w_elig[gi]    = src_valid[gi] && (w_qam[gi] <= QAM_MAX);
   end

   // First eligible source starting at the round-robin pointer, wrapping.
   always_comb begin
      w_hit = 1'b0;
      w_sel = '0;
      w_idx = r_ptr;
      for (int k = 0; k < NUM_SRC; k++) begin
         if (!w_hit && w_elig[w_idx]) begin
            w_hit = 1'b1;
            w_sel = w_idx;
         end
         w_idx = (w_idx == LAST_IDX) ? '0 : w_idx + 1'b1;
      end
   end

   assign w_ptr_nxt = (r_gidx == LAST_IDX) ? '0 : r_gidx + 1'b1;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_take        = 1'b0;
      w_fire        = 1'b0;
      w_last        = 1'b0;
      w_err_entry   = 1'b0;
      mod_signal_in = '0;
      mod_valid_in  = 1'b0;
      src_ready     = '0;
      case (r_state)
         S_IDLE: begin
            if (w_hit) begin
               w_take = 1'b1;
               // Same order as the previous frame: the modulator is already settled.
               if (r_last_qam_valid && (w_qam[w_sel] == r_qam)) begin
                  w_state_nxt = S_XFER;
               end else begin
                  w_state_nxt = S_SETTLE;
               end
            end
         end
         S_SETTLE: begin
            if (mod_error) begin
               w_err_entry = 1'b1;
               w_state_nxt = S_ERR;
            end else if (r_settle == SETTLE_TC) begin
               w_state_nxt = S_XFER;
            end
         end
         S_XFER: begin
            mod_signal_in     = w_data[r_gidx];
            mod_valid_in      = src_valid[r_gidx];
            src_ready[r_gidx] = mod_ready_out;
            w_fire            = src_valid[r_gidx] && mod_ready_out;
            // An error beats frame completion; the word is still consumed upstream.
            if (mod_error) begin
               w_err_entry = 1'b1;
               w_state_nxt = S_ERR;
            end else if (w_fire && (r_cnt == LAST_WORD)) begin
               w_last      = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         S_ERR: begin
            if (err_clr && !mod_error) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_grant          <= '0;
         r_gidx           <= '0;
         r_ptr            <= '0;
         r_qam            <= '0;
         r_last_qam_valid <= 1'b0;
         r_cnt            <= '0;
         r_settle         <= '0;
         r_frame_done     <= 1'b0;
         r_err_src        <= '0;
         r_cfg_err        <= '0;
      end else begin
         r_frame_done <= w_last;
         r_cfg_err    <= r_cfg_err | w_illegal;
         if (w_take) begin
            r_grant  <= GRANT_ONE << w_sel;
            r_gidx   <= w_sel;
            r_qam    <= w_qam[w_sel];
            r_cnt    <= '0;
            r_settle <= SETTLE_LD;
         end
         if (r_state == S_SETTLE) begin
            r_settle <= r_settle - 1'b1;
            if (w_state_nxt == S_XFER) begin
               r_last_qam_valid <= 1'b1;
            end
         end
         if (w_fire) begin
            r_cnt <= r_cnt + 1'b1;
         end
         if (w_last || w_err_entry) begin
            r_ptr   <= w_ptr_nxt;
            r_grant <= '0;
         end
         // Force a fresh settle after a fault: the modulator state is unknown.
         if (w_err_entry) begin
            r_err_src        <= r_gidx;
            r_last_qam_valid <= 1'b0;
         end
      end
   end

   assign grant      = r_grant;
   assign mod_qam    = r_qam;
   assign busy       = (r_state != S_IDLE);
   assign err        = (r_state == S_ERR);
   assign frame_done = r_frame_done;
   assign err_src    = 3'(r_err_src);
   assign cfg_err    = r_cfg_err;

endmodule
